// File: rtl/weight_pkg.sv
// Shared state encoding and sizing helpers for the weight FIFO loader.
package weight_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE         = 3'd0;
    localparam state_t ST_FLUSH        = 3'd1;
    localparam state_t ST_WAIT_ACK     = 3'd2;
    localparam state_t ST_LOAD         = 3'd3;
    localparam state_t ST_WAIT_CONSUME = 3'd4;

    localparam int DEF_PIX_WIDTH      = 8;
    localparam int DEF_SIZE_OF_WEIGHT = 5;
    localparam int DEF_WORD_WIDTH     = 32;
    localparam int DEF_CH_CNT_WIDTH   = 10;

    function automatic int kk(input int k);
        return k * k;
    endfunction

    function automatic int pix_per_word(input int word_w, input int pix_w);
        return word_w / pix_w;
    endfunction

    // Channels are word-aligned, so a partial last word still costs a full word.
    function automatic int words_per_ch(input int k, input int word_w, input int pix_w);
        return (kk(k) + pix_per_word(word_w, pix_w) - 1) / pix_per_word(word_w, pix_w);
    endfunction

endpackage

// File: rtl/weight_fifo_loader_if.sv
// DMA word stream plus weight-FIFO write port seen from the loader (master) and FIFO side (slave).
interface weight_fifo_loader_if #(
    parameter int WORD_WIDTH = 32,
    parameter int PIX_WIDTH  = 8
);
    logic [WORD_WIDTH-1:0] i_wdata;
    logic                  i_wvalid;
    logic                  o_wready;
    logic                  i_request_data;
    logic                  i_full;
    logic                  i_flush_fin;
    logic                  o_wr_en;
    logic [PIX_WIDTH-1:0]  o_data;
    logic                  o_flush;

    modport master (
        input  i_wdata, i_wvalid, i_request_data, i_full, i_flush_fin,
        output o_wready, o_wr_en, o_data, o_flush
    );

    modport slave (
        output i_wdata, i_wvalid, i_request_data, i_full, i_flush_fin,
        input  o_wready, o_wr_en, o_data, o_flush
    );
endinterface

// File: rtl/weight_word_unpacker.sv
// One-word buffer that splits a packed DMA word into pixels; slice order set by WEIGHT_FIFO_LOADER_MSB_FIRST_EN.
module weight_word_unpacker
    import weight_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int PIX_WIDTH  = DEF_PIX_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [WORD_WIDTH-1:0] word_i,
    input  logic                  word_valid_i,
    output logic                  word_ready_o,
    input  logic                  pop_i,
    input  logic                  discard_i,
    output logic [PIX_WIDTH-1:0]  pix_o,
    output logic                  pix_valid_o
);
    localparam int PPW   = pix_per_word(WORD_WIDTH, PIX_WIDTH);
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;

    logic [WORD_WIDTH-1:0]          buf_q, buf_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           full_q, full_d;
    logic [PPW-1:0][PIX_WIDTH-1:0]  slices;
    logic                           last_slice;
    logic                           drain;
    logic                           take;

    assign slices      = buf_q;
    assign last_slice  = (idx_q == IDX_W'(PPW - 1));
    assign drain       = pop_i & (last_slice | discard_i);
    // Refill is allowed in the same cycle the final slice leaves, unless the channel ends there.
    assign word_ready_o = en_i & (~full_q | (pop_i & last_slice & ~discard_i));
    assign take        = word_ready_o & word_valid_i;
    assign pix_valid_o = full_q;

`ifdef WEIGHT_FIFO_LOADER_MSB_FIRST_EN
    assign pix_o = slices[IDX_W'(PPW - 1) - idx_q];
`else
    assign pix_o = slices[idx_q];
`endif

    always_comb begin
        buf_d  = buf_q;
        idx_d  = idx_q;
        full_d = full_q;
        if (pop_i) begin
            idx_d = idx_q + 1'b1;
        end
        if (drain) begin
            full_d = 1'b0;
            idx_d  = '0;
        end
        if (take) begin
            buf_d  = word_i;
            idx_d  = '0;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q  <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            idx_q  <= idx_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/weight_fifo_loader.sv
// Loads one KxK weight channel per FIFO flush; WEIGHT_FIFO_LOADER_MSB_FIRST_EN selects MSB-first unpacking.
module weight_fifo_loader
    import weight_pkg::*;
#(
    parameter int PIX_WIDTH      = DEF_PIX_WIDTH,
    parameter int SIZE_OF_WEIGHT = DEF_SIZE_OF_WEIGHT,
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int CH_CNT_WIDTH   = DEF_CH_CNT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [CH_CNT_WIDTH-1:0] i_num_ch,
    input  logic                    i_ch_consumed,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    weight_fifo_loader_if.master    bus
);
    localparam int KK   = kk(SIZE_OF_WEIGHT);
    localparam int WPC  = words_per_ch(SIZE_OF_WEIGHT, WORD_WIDTH, PIX_WIDTH);
    localparam int PC_W = $clog2(KK + 1);
    localparam int WC_W = $clog2(WPC + 1);

    state_t                  state_q, state_d;
    logic [PC_W-1:0]         pix_cnt_q, pix_cnt_d;
    logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
    logic [CH_CNT_WIDTH-1:0] ch_cnt_q, ch_cnt_d;
    logic [CH_CNT_WIDTH-1:0] num_ch_q, num_ch_d;
    logic                    wr_en_q, wr_en_d;
    logic [PIX_WIDTH-1:0]    data_q, data_d;
    logic                    flush_q, flush_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    in_load;
    logic                    pix_valid;
    logic                    issue;
    logic                    last_pix;
    logic                    word_ready;
    logic                    word_take;
    logic [PIX_WIDTH-1:0]    pix;

    assign in_load   = (state_q == ST_LOAD);
    assign issue     = in_load & pix_valid & bus.i_request_data;
    assign last_pix  = issue & (pix_cnt_q == PC_W'(KK - 1));
    assign word_take = word_ready & bus.i_wvalid;

    // Word count caps DMA reads at one channel's worth even if the stream keeps offering.
    weight_word_unpacker #(
        .WORD_WIDTH (WORD_WIDTH),
        .PIX_WIDTH  (PIX_WIDTH)
    ) u_unpack (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .en_i         (in_load & (word_cnt_q != WC_W'(WPC))),
        .word_i       (bus.i_wdata),
        .word_valid_i (bus.i_wvalid),
        .word_ready_o (word_ready),
        .pop_i        (issue),
        .discard_i    (last_pix),
        .pix_o        (pix),
        .pix_valid_o  (pix_valid)
    );

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        word_cnt_d = word_take ? word_cnt_q + 1'b1 : word_cnt_q;
        ch_cnt_d   = ch_cnt_q;
        num_ch_d   = num_ch_q;
        wr_en_d    = issue;
        data_d     = issue ? pix : data_q;
        flush_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q | (wr_en_q & bus.i_full);

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    num_ch_d = (i_num_ch == '0) ? CH_CNT_WIDTH'(1) : i_num_ch;
                    ch_cnt_d = '0;
                    flush_d  = 1'b1;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.i_flush_fin) begin
                    pix_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (issue) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
                if (last_pix) begin
                    state_d = ST_WAIT_CONSUME;
                end
            end
            ST_WAIT_CONSUME: begin
                if (i_ch_consumed) begin
                    ch_cnt_d = ch_cnt_q + 1'b1;
                    if (ch_cnt_d == num_ch_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        flush_d = 1'b1;
                        state_d = ST_FLUSH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= '0;
            word_cnt_q <= '0;
            ch_cnt_q   <= '0;
            num_ch_q   <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            flush_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            word_cnt_q <= word_cnt_d;
            ch_cnt_q   <= ch_cnt_d;
            num_ch_q   <= num_ch_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            flush_q    <= flush_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_wready = word_ready;
    assign bus.o_wr_en  = wr_en_q;
    assign bus.o_data   = data_q;
    assign bus.o_flush  = flush_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Directed, table-driven bench for weight_fifo_loader (K=5, 32-bit words, 8-bit pixels).
`timescale 1ns/1ps
module tb_weight_fifo_loader;
    localparam int PW  = 8;
    localparam int WW  = 32;
    localparam int K   = 5;
    localparam int CW  = 10;
    localparam int KK  = 25;
    localparam int WPC = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_ch;
    logic          ch_consumed;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    weight_fifo_loader_if #(.WORD_WIDTH(WW), .PIX_WIDTH(PW)) bus ();

    weight_fifo_loader #(
        .PIX_WIDTH      (PW),
        .SIZE_OF_WEIGHT (K),
        .WORD_WIDTH     (WW),
        .CH_CNT_WIDTH   (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_num_ch      (num_ch),
        .i_ch_consumed (ch_consumed),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .bus           (bus)
    );

    typedef struct {
        int num_ch;
        int gap;
        int stall_after;
        int full_at;
        int abort_at;
        int exp_writes;
        int exp_flushes;
        int exp_done;
        int exp_err;
        int exp_words;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Write n of a job: channel c uses words 7c..7c+6, byte b of word w is 4w+b+1.
    function automatic int exp_pix(input int n);
        int c, p, w, s;
        c = n / KK;
        p = n % KK;
        w = c * WPC + p / 4;
        s = p % 4;
`ifdef WEIGHT_FIFO_LOADER_MSB_FIRST_EN
        s = 3 - s;
`endif
        return (4 * w + s + 1) & 255;
    endfunction

    function automatic logic [31:0] mkword(input int wn);
        return {8'((4 * wn + 4) & 255), 8'((4 * wn + 3) & 255),
                8'((4 * wn + 2) & 255), 8'((4 * wn + 1) & 255)};
    endfunction

    task automatic do_reset();
        rst                = 1'b1;
        start              = 1'b0;
        num_ch             = '0;
        ch_consumed        = 1'b0;
        bus.i_wdata        = '0;
        bus.i_wvalid       = 1'b0;
        bus.i_request_data = 1'b0;
        bus.i_full         = 1'b0;
        bus.i_flush_fin    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s wr_en", tag), int'(bus.o_wr_en), 0);
        check($sformatf("%s data", tag), int'(bus.o_data), 0);
        check($sformatf("%s flush", tag), int'(bus.o_flush), 0);
        check($sformatf("%s wready", tag), int'(bus.o_wready), 0);
        check($sformatf("%s busy", tag), int'(busy), 0);
        check($sformatf("%s done", tag), int'(done), 0);
        check($sformatf("%s err", tag), int'(err), 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc, writes, ch_w, flushes, acks, dones, words, first_flush;
        int ack_cd, cons_cd, stall_left, finish_cd, post_cd;
        int early, gap_writes, err_drop;
        bit finished, err_seen, full_now, abort_now, aborted, abort_chk;
        bit req_prev, cons_prev;
        string tag;
        tag = $sformatf("v%0d", idx);
        cyc = 0; writes = 0; ch_w = 0; flushes = 0; acks = 0; dones = 0; words = 0;
        first_flush = 0; ack_cd = 0; cons_cd = 0; stall_left = 0; finish_cd = 0; post_cd = 0;
        early = 0; gap_writes = 0; err_drop = 0;
        finished = 0; err_seen = 0; full_now = 0; abort_now = 0; aborted = 0; abort_chk = 0;

        do_reset();
        num_ch             = CW'(v.num_ch);
        start              = 1'b1;
        bus.i_request_data = 1'b1;
        bus.i_wvalid       = 1'b1;
        bus.i_wdata        = mkword(0);
        req_prev           = 1'b1;
        cons_prev          = 1'b0;

        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (abort_chk) begin
                check_all_zero($sformatf("%s abort", tag));
                abort_chk = 0;
            end
            if (bus.o_flush) begin
                flushes++;
                if (first_flush == 0) first_flush = cyc;
                ack_cd = 2;
            end
            if (bus.o_wr_en) begin
                if (acks < flushes) early++;
                if (!req_prev) gap_writes++;
                check($sformatf("%s data[%0d]", tag, writes), int'(bus.o_data), exp_pix(writes));
                writes++;
                ch_w++;
                if (ch_w == KK) begin
                    ch_w    = 0;
                    cons_cd = 3;
                end
                if (writes == v.abort_at) abort_now = 1;
                if (writes == v.stall_after) stall_left = 10;
                if (writes == v.full_at) full_now = 1;
            end
            if (err) err_seen = 1;
            else if (err_seen) err_drop++;
            if (done) begin
                dones++;
                check($sformatf("%s done_lat", tag), int'(cons_prev), 1);
                finish_cd = 3;
            end

            start           = 1'b0;
            rst             = 1'b0;
            bus.i_flush_fin = 1'b0;
            ch_consumed     = 1'b0;
            if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) begin
                    bus.i_flush_fin = 1'b1;
                    acks++;
                end
            end
            if (cons_cd > 0) begin
                cons_cd--;
                if (cons_cd == 0) ch_consumed = 1'b1;
            end
            bus.i_request_data = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            bus.i_wvalid = (v.gap != 0) ? (cyc % 3 == 0) : 1'b1;
            bus.i_wdata  = mkword(words);
            bus.i_full   = full_now;
            full_now     = 0;
            if (abort_now) begin
                rst       = 1'b1;
                abort_now = 0;
                aborted   = 1;
                abort_chk = 1;
                post_cd   = 12;
            end
            if (finish_cd > 0) begin
                finish_cd--;
                if (finish_cd == 0) finished = 1;
            end
            if (post_cd > 0) begin
                post_cd--;
                if (post_cd == 0) finished = 1;
            end
            req_prev  = bus.i_request_data;
            cons_prev = ch_consumed;
            #1;
            if (bus.o_wready && bus.i_wvalid && !rst) words++;
        end

        check($sformatf("%s completed", tag), int'(finished), 1);
        check($sformatf("%s flush_lat", tag), first_flush, 1);
        check($sformatf("%s writes", tag), writes, v.exp_writes);
        check($sformatf("%s flushes", tag), flushes, v.exp_flushes);
        check($sformatf("%s dones", tag), dones, v.exp_done);
        check($sformatf("%s words", tag), words, v.exp_words);
        check($sformatf("%s err", tag), int'(err), v.exp_err);
        check($sformatf("%s err_sticky", tag), err_drop, 0);
        check($sformatf("%s early_write", tag), early, 0);
        check($sformatf("%s stall_write", tag), gap_writes, 0);
        check($sformatf("%s busy_end", tag), int'(busy), 0);
        check($sformatf("%s aborted", tag), int'(aborted), (v.abort_at > 0) ? 1 : 0);
    endtask

    initial begin
        //           nch gap stl full abt  wr fl dn er words
        vecs[0] = '{1, 0, 0,  0, 0,  25, 1, 1, 0, 7};
        vecs[1] = '{1, 1, 0,  0, 0,  25, 1, 1, 0, 7};
        vecs[2] = '{1, 0, 12, 0, 0,  25, 1, 1, 0, 7};
        vecs[3] = '{3, 0, 0,  0, 0,  75, 3, 1, 0, 21};
        vecs[4] = '{1, 0, 0,  5, 0,  25, 1, 1, 1, 7};
        vecs[5] = '{1, 0, 0,  0, 10, 10, 1, 0, 0, 3};
        vecs[6] = '{0, 0, 0,  0, 0,  25, 1, 1, 0, 7};

        do_reset();
        check_all_zero("reset");

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Stray i_start / i_ch_consumed while waiting for the flush ack must be ignored.
        do_reset();
        num_ch = CW'(2);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hs flush", int'(bus.o_flush), 1);
        start       = 1'b1;
        ch_consumed = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        ch_consumed = 1'b0;
        check("hs busy", int'(busy), 1);
        check("hs no_reflush", int'(bus.o_flush), 0);
        repeat (3) @(negedge clk);
        check("hs still_wait_flush", int'(bus.o_flush), 0);
        check("hs still_wait_wr", int'(bus.o_wr_en), 0);
        check("hs still_wait_done", int'(done), 0);
        check("hs still_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hs reset_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_fifo_loader.md
Name: weight_fifo_loader

Overview:
Producer side of the weight FIFO write interface. It takes packed weight words from the weight DMA stream and unpacks them into single pixels. It drives the FIFO's write-enable, data and flush inputs, obeying the FIFO's request_data, full and flush_fin outputs. One K×K kernel channel is loaded per flush, for a programmed number of channels, and each next channel is loaded only after the deconv core signals the current one consumed.

Parameters:
PIX_WIDTH, 8, pixel width in bits
SIZE_OF_WEIGHT, 5, kernel side K; a channel is K*K pixels
WORD_WIDTH, 32, DMA word width; must be a multiple of PIX_WIDTH; PIX_PER_WORD = WORD_WIDTH/PIX_WIDTH (localparam)
CH_CNT_WIDTH, 10, width of the channel-count input

Ports:
i_clk  in  1  single clock
i_rst  in  1  synchronous, active-high reset
i_start  in  1  pulse: begin a load job (ignored unless IDLE)
i_num_ch  in  CH_CNT_WIDTH  channels in the job, sampled on i_start; 0 is treated as 1
i_wdata  in  WORD_WIDTH  packed weight word from DMA
i_wvalid  in  1  i_wdata valid
o_wready  out  1  loader accepts word this cycle
i_request_data  in  1  FIFO request_data
i_full  in  1  FIFO s_full
i_flush_fin  in  1  FIFO flush_fin acknowledge
o_wr_en  out  1  FIFO wr_en (registered)
o_data  out  PIX_WIDTH  FIFO data_in (registered)
o_flush  out  1  FIFO i_flush, one-cycle pulse (registered)
i_ch_consumed  in  1  core pulse: current channel fully used
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when the last channel is consumed
o_err  out  1  sticky: a write was issued while i_full=1

Behaviour:
- Reset: all outputs 0, FSM=IDLE, all counters 0, word buffer empty. Reset mid-job aborts immediately with no further flush or write.
- FSM states: IDLE, FLUSH, WAIT_ACK, LOAD, WAIT_CONSUME.
- IDLE→FLUSH on i_start.
- FLUSH: o_flush=1 for exactly one cycle, then →WAIT_ACK.
- WAIT_ACK: hold until i_flush_fin=1, then →LOAD with pix_cnt=0.
- LOAD:
  - Word buffer holds one word plus a byte index.
  - o_wready=1 only in LOAD with the buffer empty; a word is taken on o_wready&i_wvalid.
  - A pixel is issued when the buffer is non-empty and i_request_data=1: next cycle o_wr_en=1 and o_data=the selected slice. Default slice order is bits [PIX_WIDTH-1:0] first, ascending.
  - At most one pixel per cycle; o_wr_en=0 otherwise and o_data is held.
  - Each issue increments pix_cnt. When pix_cnt reaches K*K the buffer is emptied, discarding any unused slices, and the state →WAIT_CONSUME.
  - Channels are word-aligned: each channel uses ceil(K*K/PIX_PER_WORD) words, i.e. 7 words for K=5 at 32/8.
  - The buffer is marked empty after its last slice is issued; a new word may be accepted in the same cycle its last slice issues (no bubble).
- Full rule: if i_full=1 in a cycle where o_wr_en=1, o_err is set and held until reset. The loader does not retry; pix_cnt is still advanced.
- WAIT_CONSUME: on i_ch_consumed, ch_cnt++.
  - If ch_cnt reaches the job count: o_done pulses the next cycle and the state →IDLE.
  - Otherwise →FLUSH.
- i_ch_consumed in any other state is ignored. i_start while busy is ignored.
- i_request_data low stalls LOAD indefinitely with no timeout.
- Latency: i_start to o_flush is 1 cycle. i_flush_fin to the first o_wr_en is ≥2 cycles (word accept, then issue).

Optional Feature:
WEIGHT_FIFO_LOADER_MSB_FIRST_EN
- Defined: slices are issued most-significant first, starting from bits [WORD_WIDTH-1 -: PIX_WIDTH].
- Undefined: LSB-first ordering as above. No other behaviour changes.

Decomposition:
- Shared package (weight_pkg): FSM state enum typedef, K*K localparam, PIX_PER_WORD, and a function for words per channel.
- One natural sub-module: weight_word_unpacker. It contains the word buffer, byte index and slice mux, and provides a valid/ready word input and a pixel output with a pop strobe.

Test Plan:
- K=5, 1 channel, words 0x04030201…0x1C1B1A19, request_data=1 → one o_flush; 25 writes with o_data 0x01..0x19 in order; bytes 0x1A-0x1C discarded; o_done one cycle after i_ch_consumed.
- i_wvalid gaps (1 valid in 3 cycles) → same 25-value sequence; o_wr_en only while a word is buffered; o_wready never high with the buffer full.
- i_request_data dropped for 10 cycles after pixel 12 → no writes during the gap; resumes at 0x0D; total 25 writes.
- i_num_ch=3 → exactly 3 flush pulses; each followed by 25 writes only after i_flush_fin; pixel 1 of channel 2 comes from the 8th DMA word; single o_done.
- i_full forced high during write 5 → o_err=1 and stays 1; the remaining 20 writes still issued.
- i_rst asserted at write 10 → next cycle all outputs 0; state IDLE; a subsequent i_start restarts with o_flush.
- With WEIGHT_FIFO_LOADER_MSB_FIRST_EN defined: word 0x04030201 → 0x04, 0x03, 0x02, 0x01.
